// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT_MAX = 255;

  typedef enum logic [2:0] {
    IDLE,
    I_BUSY,
    D_BUSY,
    I_DONE,
    D_DONE
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory bus, alternating on ties.
// Optional busy-cycle timeout when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              m_req,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              err
);

  state_t state_q, state_d;
  grant_t last_q;
  logic   d_req, grant_i, grant_d, busy, timeout;

  // A halted core may still issue loads/stores, so halt only masks the fetch side.
  always_comb begin
    d_req   = d_rd | d_wr;
    grant_d = (state_q == IDLE) && d_req && (!i_req || halt || (last_q == GNT_I));
    grant_i = (state_q == IDLE) && i_req && !halt && !grant_d;
    busy    = (state_q == I_BUSY) || (state_q == D_BUSY);
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       err_q;

  // Fires on the TIMEOUT_MAX-th busy cycle that has no ack.
  assign timeout = busy && !m_ack && (tmo_cnt_q == 8'(TIMEOUT_MAX - 1));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (grant_i || grant_d)
        tmo_cnt_q <= '0;
      else if (busy)
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      err_q <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d)      state_d = D_BUSY;
        else if (grant_i) state_d = I_BUSY;
      end
      I_BUSY:  if (m_ack || timeout) state_d = I_DONE;
      D_BUSY:  if (m_ack || timeout) state_d = D_DONE;
      I_DONE:  state_d = IDLE;
      D_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    i_done = (state_q == I_DONE);
    d_done = (state_q == D_DONE);
  end

  // Bus operands are latched at grant; requesters may change them once done is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= GNT_I;
      m_req   <= 1'b0;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (grant_d) begin
        m_req   <= 1'b1;
        m_wr    <= d_wr;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (grant_i) begin
        m_req  <= 1'b1;
        m_wr   <= 1'b0;
        m_addr <= i_addr;
      end else if ((busy && m_ack) || timeout) begin
        m_req <= 1'b0;
      end

      if (state_q == I_BUSY && m_ack) i_rdata <= m_rdata;
      if (state_q == D_BUSY && m_ack) d_rdata <= m_rdata;

      if (state_q == I_DONE) last_q <= GNT_I;
      if (state_q == D_DONE) last_q <= GNT_D;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus arbitration/reset/timeout sequences.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              halt = 1'b0;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              d_rd = 1'b0;
  logic              d_wr = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              m_req;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata = '0;
  logic              m_ack = 1'b0;
  logic              err;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .halt(halt),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          delay;
    logic [15:0] rdata;
    logic        exp_wr;
  } vec_t;

  vec_t        vecs[5];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [15:0] exp_i  = '0;
  logic [15:0] exp_d  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst   = 1'b0;
    exp_i = '0;
    exp_d = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    if (v.is_d) begin
      d_rd = v.rd; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    step();
    chk($sformatf("v%0d_m_req", idx), m_req, 1);
    chk($sformatf("v%0d_m_wr", idx), m_wr, v.exp_wr);
    chk($sformatf("v%0d_m_addr", idx), m_addr, v.addr);
    if (v.exp_wr) chk($sformatf("v%0d_m_wdata", idx), m_wdata, v.wdata);
    for (int k = 0; k < v.delay; k++) begin
      step();
      chk($sformatf("v%0d_m_req_wait", idx), m_req, 1);
    end
    m_ack = 1'b1; m_rdata = v.rdata;
    step();
    m_ack = 1'b0; m_rdata = 16'hDEAD;
    if (v.is_d) exp_d = v.rdata;
    else        exp_i = v.rdata;
    chk($sformatf("v%0d_i_done", idx), i_done, !v.is_d);
    chk($sformatf("v%0d_d_done", idx), d_done, v.is_d);
    chk($sformatf("v%0d_m_req_drop", idx), m_req, 0);
    chk($sformatf("v%0d_err", idx), err, 0);
    chk($sformatf("v%0d_i_rdata", idx), i_rdata, exp_i);
    chk($sformatf("v%0d_d_rdata", idx), d_rdata, exp_d);
    i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    step();
    chk($sformatf("v%0d_done_clear", idx), {i_done, d_done}, 2'b00);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 3, 16'hB123, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h3000, 16'h0000, 0, 16'h7FFF, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h4004, 16'hA5A5, 1, 16'h0102, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h5000, 16'h0F0F, 2, 16'h8001, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 16'hFFFE, 16'h0000, 0, 16'h0001, 1'b0};

    do_reset();
    chk("rst_m_req", m_req, 0);
    chk("rst_m_wr", m_wr, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_i_done", i_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_err", err, 0);

    for (int n = 0; n < 5; n++) run_vec(vecs[n], n);

    // Tie after reset: data first, then a renewed store ties with the fetch and loses.
    do_reset();
    i_req = 1'b1; i_addr = 16'h0040;
    d_wr = 1'b1; d_addr = 16'h1000; d_wdata = 16'h55AA;
    step();
    chk("tie1_m_req", m_req, 1);
    chk("tie1_m_wr", m_wr, 1);
    chk("tie1_m_addr", m_addr, 16'h1000);
    chk("tie1_m_wdata", m_wdata, 16'h55AA);
    m_ack = 1'b1; m_rdata = 16'h0BAD;
    step();
    m_ack = 1'b0;
    chk("tie1_d_done", d_done, 1);
    chk("tie1_i_done", i_done, 0);
    chk("tie1_d_rdata", d_rdata, 16'h0BAD);
    d_addr = 16'h1002; d_wdata = 16'h1111;
    step();
    chk("tie1_idle_m_req", m_req, 0);
    step();
    chk("tie2_m_req", m_req, 1);
    chk("tie2_m_wr", m_wr, 0);
    chk("tie2_m_addr", m_addr, 16'h0040);
    m_ack = 1'b1; m_rdata = 16'hC0DE;
    step();
    m_ack = 1'b0;
    chk("tie2_i_done", i_done, 1);
    chk("tie2_i_rdata", i_rdata, 16'hC0DE);
    i_req = 1'b0;
    step();
    step();
    chk("tie3_m_wr", m_wr, 1);
    chk("tie3_m_addr", m_addr, 16'h1002);
    chk("tie3_m_wdata", m_wdata, 16'h1111);
    m_ack = 1'b1; m_rdata = 16'h2222;
    step();
    m_ack = 1'b0;
    chk("tie3_d_done", d_done, 1);
    d_wr = 1'b0;
    step();

    // Halt masks fetch; a halt raised mid-fetch does not abort it.
    halt = 1'b1; i_req = 1'b1; i_addr = 16'h0080; d_rd = 1'b1; d_addr = 16'h2000;
    step();
    chk("halt_m_wr", m_wr, 0);
    chk("halt_m_addr", m_addr, 16'h2000);
    m_ack = 1'b1; m_rdata = 16'h1234;
    step();
    m_ack = 1'b0;
    chk("halt_d_done", d_done, 1);
    chk("halt_d_rdata", d_rdata, 16'h1234);
    d_rd = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("halt_no_fetch", {m_req, i_done}, 2'b00);
    end
    halt = 1'b0;
    step();
    chk("unhalt_m_req", m_req, 1);
    chk("unhalt_m_addr", m_addr, 16'h0080);
    halt = 1'b1;
    step();
    step();
    chk("halt_mid_fetch_m_req", m_req, 1);
    m_ack = 1'b1; m_rdata = 16'h4321;
    step();
    m_ack = 1'b0;
    chk("halt_mid_fetch_i_done", i_done, 1);
    chk("halt_mid_fetch_i_rdata", i_rdata, 16'h4321);
    i_req = 1'b0; halt = 1'b0;
    step();

    // Reset during D_BUSY abandons the load; a late ack is ignored.
    d_rd = 1'b1; d_addr = 16'h3000;
    step();
    chk("rstmid_m_req", m_req, 1);
    rst = 1'b1; d_rd = 1'b0;
    step();
    chk("rstmid_m_req_low", m_req, 0);
    chk("rstmid_d_done", d_done, 0);
    rst = 1'b0; exp_i = '0; exp_d = '0;
    m_ack = 1'b1; m_rdata = 16'h9999;
    step();
    m_ack = 1'b0;
    chk("rstmid_ack_d_done", d_done, 0);
    chk("rstmid_ack_m_req", m_req, 0);
    chk("rstmid_ack_d_rdata", d_rdata, 0);
    step();
    chk("rstmid_after", {m_req, i_done, d_done}, 3'b000);

    // Memory never answers.
    i_req = 1'b1; i_addr = 16'h00F0;
    step();
    chk("noack_m_req", m_req, 1);
`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int cnt = 1;
      bit dropped = 1'b0;
      for (int k = 0; k < 300 && !dropped; k++) begin
        step();
        if (m_req) cnt++;
        else begin
          dropped = 1'b1;
          chk("tmo_i_done", i_done, 1);
          chk("tmo_err", err, 1);
          chk("tmo_i_rdata", i_rdata, exp_i);
        end
      end
      chk("tmo_dropped", dropped, 1);
      chk("tmo_busy_cycles", cnt, 255);
      i_req = 1'b0;
      step();
      chk("tmo_after", {err, i_done}, 2'b00);
    end
`else
    begin
      bit err_seen = 1'b0;
      for (int k = 0; k < 300; k++) begin
        step();
        if (err !== 1'b0) err_seen = 1'b1;
      end
      chk("hold_m_req", m_req, 1);
      chk("hold_err", err_seen, 0);
      m_ack = 1'b1; m_rdata = 16'h6666;
      step();
      m_ack = 1'b0;
      chk("hold_i_done", i_done, 1);
      chk("hold_i_rdata", i_rdata, 16'h6666);
      i_req = 1'b0;
      step();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
